fetch_prefetcher: RTL
=====================

FETCH_PREFETCHER -- requirements
Module: fetch_prefetcher

Interface
REQ-001 Parameter: width, 32, instruction and address width in bits.
REQ-002 Parameter: RESET_PC, 32'h00000060, fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: mem_read  output  1  instruction memory read request.
REQ-006 Port: mem_address  output  width  read address; word-aligned.
REQ-007 Port: mem_rdata  input  width  read data; valid when mem_resp=1.
REQ-008 Port: mem_resp  input  1  one-cycle response strobe completing the current read.
REQ-009 Port: q_data  output  width  instruction pushed to the downstream instruction queue.
REQ-010 Port: q_load  output  1  one-cycle push strobe to the queue.
REQ-011 Port: queue_full  input  1  queue last entry occupied; a push while high is lost.
REQ-012 Port: redirect  input  1  branch/jump redirect strobe.
REQ-013 Port: redirect_pc  input  width  new fetch address; bits [1:0] are forced to 0.

Function
REQ-014 The block SHALL implement states IDLE, REQ, FULL and FLUSH.
REQ-015 IDLE: mem_read=0; next state REQ when queue_full=0, otherwise IDLE.
REQ-016 REQ: mem_read=1 and mem_address=pc, both held stable until mem_resp.
REQ-017 REQ with mem_resp=1, redirect=0 and queue_full=0: q_load=1 and q_data=mem_rdata in that same cycle; pc<=pc+4; stay in REQ.
REQ-018 REQ with mem_resp=1, redirect=0 and queue_full=1: latch mem_rdata into the hold register; pc<=pc+4; go to FULL.
REQ-019 FULL: mem_read=0. When queue_full=0: q_load=1 and q_data=hold, then go to REQ.
REQ-020 q_load SHALL never be asserted while queue_full=1.
REQ-021 Redirect in IDLE or FULL: pc<=redirect_pc, discard any held instruction, go to IDLE; no push occurs that cycle.
REQ-022 Redirect in REQ with mem_resp=1: discard the response, pc<=redirect_pc, go to IDLE.
REQ-023 Redirect in REQ with mem_resp=0: latch target; go to FLUSH.
REQ-024 FLUSH: keep mem_read=1 with the old address until mem_resp, then discard the data.
REQ-025 FLUSH on mem_resp: pc<=latched target, go to IDLE.
REQ-026 A further redirect in FLUSH SHALL overwrite the latched target; the last one wins.
REQ-027 pc arithmetic SHALL be modulo 2^width; 32'hFFFFFFFC+4 wraps to 0.
REQ-028 At most one push SHALL occur per fetched word; no word is pushed twice or skipped, except on redirect.

Reset
REQ-029 While rst=1: state=IDLE, pc=RESET_PC, hold register=0, latched target=0, mem_read=0, q_load=0, q_data=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding read; a mem_resp arriving after reset while in IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN: when defined, add output stall_count (32 bits). It resets to 0 and increments every cycle in FULL, or in IDLE with queue_full=1, saturating at all-ones.
REQ-032 When FETCH_STALL_CNT_EN is undefined, the port and the counter SHALL be absent and the rest of the behaviour is identical.

Structure
REQ-033 A shared package fetch_types SHALL hold the state enum (IDLE, REQ, FULL, FLUSH) and the RESET_PC default constant.
REQ-034 No sub-module is required; the hold register and pc register are inline, and the stall counter (when enabled) is inline.

Verification
REQ-035 Reset release with mem_resp every second cycle and queue_full=0: mem_address sequence 0x60, 0x64, 0x68; each data word is pushed once on its mem_resp cycle.
REQ-036 queue_full=1 at the mem_resp for 0x64 (data 0xDEADBEEF): q_load=0, state FULL; queue_full drops 3 cycles later -> one q_load with 0xDEADBEEF; next address is 0x68.
REQ-037 Redirect to 0x203 one cycle before mem_resp: response discarded, no push; next request address is 0x200.
REQ-038 Two redirects in FLUSH (0x400, then 0x500): next request address is 0x500.
REQ-039 pc=0xFFFFFFFC with a normal response: push occurs, next address is 0x00000000.
REQ-040 With FETCH_STALL_CNT_EN defined, queue_full held 5 cycles in FULL: stall_count=5; rst -> 0.

Source files
------------

// File: rtl/fetch_types_pkg.sv
// Shared types for the instruction fetch prefetcher: FSM state encoding and
// the default post-reset fetch address.
package fetch_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL,
    FLUSH
  } state_e;

endpackage

// File: rtl/fetch_prefetcher.sv
// Instruction prefetcher: issues sequential word reads to instruction memory
// and pushes returned words into a downstream queue. A one-entry hold register
// absorbs a response that arrives while the queue is full. Redirects either
// take effect at once or, with a read in flight, wait for that read to drain.
// Optional stall counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_prefetcher
  import fetch_types::*;
#(
  parameter int unsigned       width    = 32,
  parameter logic [width-1:0]  RESET_PC = RESET_PC_DEFAULT[width-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_read,
  output logic [width-1:0] mem_address,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_resp,
  output logic [width-1:0] q_data,
  output logic             q_load,
  input  logic             queue_full,
  input  logic             redirect,
  input  logic [width-1:0] redirect_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  localparam logic [width-1:0] PcStep = width'(4);

  state_e           state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [width-1:0] hold_q, hold_d;
  logic [width-1:0] target_q, target_d;
  logic [width-1:0] redir_pc;

  // Redirect targets are always word-aligned; the low bits are dropped.
  assign redir_pc = {redirect_pc[width-1:2], 2'b00};

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign mem_address = pc_q;

  // State, pc, hold and redirect-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      target_q <= target_d;
    end
  end

  // Next-state logic and memory/queue handshake outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    target_d = target_q;
    mem_read = 1'b0;
    q_load   = 1'b0;
    q_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d   = redir_pc;
          hold_d = '0;
        end else if (!queue_full) begin
          state_d = REQ;
        end
      end

      REQ: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          if (redirect) begin
            pc_d    = redir_pc;
            state_d = IDLE;
          end else if (!queue_full) begin
            q_load = 1'b1;
            q_data = mem_rdata;
            pc_d   = pc_q + PcStep;
          end else begin
            hold_d  = mem_rdata;
            pc_d    = pc_q + PcStep;
            state_d = FULL;
          end
        end else if (redirect) begin
          // Read already in flight: remember where to go once it completes.
          target_d = redir_pc;
          state_d  = FLUSH;
        end
      end

      FULL: begin
        if (redirect) begin
          pc_d    = redir_pc;
          hold_d  = '0;
          state_d = IDLE;
        end else if (!queue_full) begin
          q_load  = 1'b1;
          q_data  = hold_q;
          state_d = REQ;
        end
      end

      FLUSH: begin
        // Keep the stale request up until memory completes it, then drop data.
        mem_read = 1'b1;
        if (redirect) begin
          target_d = redir_pc;
        end
        if (mem_resp) begin
          pc_d    = redirect ? redir_pc : target_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_read = 1'b0;
      q_load   = 1'b0;
      q_data   = '0;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles lost to a full queue, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == FULL || (state_q == IDLE && queue_full)) && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
